// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller with dead time and leading-zero suppression
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            WE,
    input  logic [2:0]      WADDR,
    input  logic [3:0]      WDATA,
    input  logic            WDP,
    input  logic [NDIG-1:0] DIG_EN,
    input  logic            LZS,
    output logic [3:0]      NIBBLE,
    output logic            DP,
    output logic [NDIG-1:0] DIG,
    output logic            BLANK_O,
    output logic [2:0]      SCAN_IDX
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BL = CW'(BLANK);
    localparam logic [2:0] TOP = 3'(NDIG - 1);
    localparam logic [NDIG-1:0] ONE = {{(NDIG-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [3:0]    digit [8];
    logic [3:0]    val [8];
    logic [7:0]    dp_r, dpv, en;
    logic          legal, wrap, lit, lit_n, sup, on;

    // next-slot state, write-forwarded register view and suppression decision
    always_comb begin
        legal = {1'b0, WADDR} < 4'(NDIG);
        wrap  = cnt == LAST;
        cnt_n = wrap ? '0 : cnt + 1'b1;
        idx_n = wrap ? (idx == TOP ? 3'd0 : idx + 3'd1) : idx;
        en    = 8'(DIG_EN);
        for (int i = 0; i < 8; i++) begin
            val[i] = (WE && legal && WADDR == 3'(i)) ? WDATA : digit[i];
            dpv[i] = (WE && legal && WADDR == 3'(i)) ? WDP : dp_r[i];
        end
        sup = LZS && idx_n != 3'd0 && val[idx_n] == 4'd0 && !dpv[idx_n];
        for (int j = 0; j < 8; j++)
            if (3'(j) > idx_n && en[j] && (val[j] != 4'd0 || dpv[j])) sup = 1'b0;
        lit_n = wrap ? (en[idx_n] && !sup) : lit;
        on    = cnt_n >= BL && lit_n;
    end

    // digit register file; out-of-range addresses are dropped
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < 8; i++) digit[i] <= '0;
            dp_r <= '0;
        end else if (WE && legal) begin
            digit[WADDR] <= WDATA;
            dp_r[WADDR]  <= WDP;
        end
    end

    // prescaler, slot latch and registered digit drive
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt      <= '0;
            idx      <= '0;
            lit      <= en[0];
            NIBBLE   <= '0;
            DP       <= 1'b0;
            SCAN_IDX <= '0;
            DIG      <= '0;
            BLANK_O  <= 1'b1;
        end else begin
            cnt <= cnt_n;
            idx <= idx_n;
            lit <= lit_n;
            if (wrap) begin
                NIBBLE   <= val[idx_n];
                DP       <= dpv[idx_n];
                SCAN_IDX <= idx_n;
            end
            DIG     <= on ? ONE << idx_n : '0;
            BLANK_O <= !on;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed tests for seg_scan_ctrl with NDIG=4, DIV=8, BLANK=2
module tb_seg_scan_ctrl;
    logic       clk = 0, rstn = 0, we = 0, wdp = 0, lzs = 0;
    logic [2:0] waddr = 0;
    logic [3:0] wdata = 0;
    logic [3:0] dig_en = 4'hF;
    logic [3:0] nibble, dig;
    logic       dp, blank_o;
    logic [2:0] scan_idx;
    int errors = 0, checks = 0, pos = 0;

    seg_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK(2)) dut (
        .CLK(clk), .RSTN(rstn), .WE(we), .WADDR(waddr), .WDATA(wdata), .WDP(wdp),
        .DIG_EN(dig_en), .LZS(lzs), .NIBBLE(nibble), .DP(dp), .DIG(dig),
        .BLANK_O(blank_o), .SCAN_IDX(scan_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task goto_slot(input int s, input int c);
        while (pos % 32 != s * 8 + c) tick();
    endtask

    task wr(input int a, input logic [3:0] d, input logic p);
        we = 1; waddr = 3'(a); wdata = d; wdp = p;
        tick();
        we = 0;
    endtask

    task test_reset();
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        pos = 0;
        checks++;
        if ({dig, blank_o, scan_idx, nibble, dp} !== {4'b0, 1'b1, 3'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got dig=%b blank=%b idx=%0d nib=%h dp=%b want dig=0000 blank=1 idx=0 nib=0 dp=0",
                     dig, blank_o, scan_idx, nibble, dp);
        end
        rstn = 1;
    endtask

    task test_scan();
        logic [3:0] e;
        int s, c;
        for (int i = 0; i < 4; i++) wr(i, 4'(i), 1'b0);
        repeat (64) begin
            s = (pos % 32) / 8;
            c = pos % 8;
            e = (c < 2) ? 4'b0 : 4'(1 << s);
            checks++;
            if ({dig, blank_o, scan_idx, nibble} !== {e, c < 2, 3'(s), 4'(s)}) begin
                errors++;
                $display("FAIL scan slot=%0d cnt=%0d got dig=%b blank=%b idx=%0d nib=%h want dig=%b blank=%b idx=%0d nib=%h",
                         s, c, dig, blank_o, scan_idx, nibble, e, c < 2, s, s);
            end
            tick();
        end
    endtask

    task test_forwarding();
        goto_slot(0, 7);
        wr(1, 4'hA, 1'b1);
        checks++;
        if ({nibble, dp, scan_idx, dig, blank_o} !== {4'hA, 1'b1, 3'd1, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL fwd_wrap got nib=%h dp=%b idx=%0d dig=%b blank=%b want nib=a dp=1 idx=1 dig=0000 blank=1",
                     nibble, dp, scan_idx, dig, blank_o);
        end
        goto_slot(1, 3);
        wr(1, 4'h5, 1'b0);
        checks++;
        if ({nibble, dp, dig} !== {4'hA, 1'b1, 4'b0010}) begin
            errors++;
            $display("FAIL fwd_hold got nib=%h dp=%b dig=%b want nib=a dp=1 dig=0010", nibble, dp, dig);
        end
        goto_slot(1, 0);
        checks++;
        if ({nibble, dp} !== {4'h5, 1'b0}) begin
            errors++;
            $display("FAIL fwd_next got nib=%h dp=%b want nib=5 dp=0", nibble, dp);
        end
    endtask

    task test_lzs();
        logic [3:0] want [4];
        lzs = 1;
        wr(3, 4'h0, 1'b0);
        wr(2, 4'h0, 1'b0);
        wr(1, 4'h4, 1'b0);
        wr(0, 4'h0, 1'b0);
        want = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        goto_slot(0, 0);
        for (int s = 0; s < 4; s++) begin
            goto_slot(s, 4);
            checks++;
            if ({dig, blank_o} !== {want[s], want[s] == 4'b0}) begin
                errors++;
                $display("FAIL lzs slot=%0d got dig=%b blank=%b want dig=%b blank=%b",
                         s, dig, blank_o, want[s], want[s] == 4'b0);
            end
        end
        wr(3, 4'h0, 1'b1);
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        goto_slot(0, 0);
        for (int s = 0; s < 4; s++) begin
            goto_slot(s, 4);
            checks++;
            if ({dig, blank_o, dp} !== {want[s], 1'b0, s == 3}) begin
                errors++;
                $display("FAIL lzs_dp slot=%0d got dig=%b blank=%b dp=%b want dig=%b blank=0 dp=%b",
                         s, dig, blank_o, dp, want[s], s == 3);
            end
        end
        lzs = 0;
    endtask

    task test_dig_en();
        logic [3:0] e;
        int s, c;
        dig_en = 4'b1010;
        goto_slot(0, 0);
        repeat (32) begin
            s = (pos % 32) / 8;
            c = pos % 8;
            e = (c >= 2 && dig_en[s]) ? 4'(1 << s) : 4'b0;
            checks++;
            if ({dig, blank_o, scan_idx} !== {e, e == 4'b0, 3'(s)}) begin
                errors++;
                $display("FAIL dig_en slot=%0d cnt=%0d got dig=%b blank=%b idx=%0d want dig=%b blank=%b idx=%0d",
                         s, c, dig, blank_o, scan_idx, e, e == 4'b0, s);
            end
            tick();
        end
        dig_en = 4'hF;
    endtask

    task test_illegal_addr();
        logic [3:0] nibs [4];
        logic       dps [4];
        nibs = '{4'h0, 4'h4, 4'h0, 4'h0};
        dps  = '{1'b0, 1'b0, 1'b0, 1'b1};
        wr(6, 4'hF, 1'b1);
        goto_slot(0, 0);
        for (int s = 0; s < 4; s++) begin
            goto_slot(s, 4);
            checks++;
            if ({nibble, dp, dig} !== {nibs[s], dps[s], 4'(1 << s)}) begin
                errors++;
                $display("FAIL illegal_addr slot=%0d got nib=%h dp=%b dig=%b want nib=%h dp=%b dig=%b",
                         s, nibble, dp, dig, nibs[s], dps[s], 4'(1 << s));
            end
        end
    endtask

    task test_reset_mid_slot();
        goto_slot(2, 5);
        rstn = 0;
        tick();
        pos = 0;
        checks++;
        if ({dig, blank_o, scan_idx, nibble, dp} !== {4'b0, 1'b1, 3'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got dig=%b blank=%b idx=%0d nib=%h dp=%b want dig=0000 blank=1 idx=0 nib=0 dp=0",
                     dig, blank_o, scan_idx, nibble, dp);
        end
        rstn = 1;
        for (int s = 0; s < 4; s++) begin
            goto_slot(s, 4);
            checks++;
            if ({nibble, dp, dig} !== {4'h0, 1'b0, 4'(1 << s)}) begin
                errors++;
                $display("FAIL reset_cleared slot=%0d got nib=%h dp=%b dig=%b want nib=0 dp=0 dig=%b",
                         s, nibble, dp, dig, 4'(1 << s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_forwarding();
        test_lzs();
        test_dig_en();
        test_illegal_addr();
        test_reset_mid_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's common-cathode 7-segment display bank. Holds one 4-bit hex value and a decimal point per digit. Rotates a single shared hex-to-7-segment decoder across NDIG digits, driving the decoder's 4-bit input and the one-hot digit selects. Inserts dead time between digits to prevent ghosting, and applies optional leading-zero suppression. Sits between the music player's status/counter logic (the writer) and the decoder plus pins.

Parameters:
NDIG, 8, number of digits scanned; legal range 2..8; digit 0 is the rightmost (least significant).
DIV, 50000, clock cycles per digit slot; must be greater than BLANK+1.
BLANK, 16, dead-time cycles at the start of each slot with all digits off; 0 is legal.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RSTN  in  1  synchronous active-low reset.
WE  in  1  write strobe for the digit register file.
WADDR  in  3  digit index to write; writes with WADDR >= NDIG are ignored.
WDATA  in  4  hex value to store.
WDP  in  1  decimal point to store with WDATA.
DIG_EN  in  NDIG  per-digit enable mask.
LZS  in  1  leading-zero suppression enable.
NIBBLE  out  4  value fed to the shared hex decoder.
DP  out  1  decimal point for the current digit.
DIG  out  NDIG  one-hot active-high digit select; all-zero when nothing is lit.
BLANK_O  out  1  1 = downstream forces all segments off.
SCAN_IDX  out  3  index of the current slot's digit.

Behaviour:
- Clocking and reset: every flop is clocked by CLK. RSTN is sampled only at the clock edge (no asynchronous path).
- Reset values (RSTN=0 at an edge):
  - prescaler cnt=0, idx=0, all digit registers and DP bits = 0;
  - NIBBLE=0, DP=0, DIG=0, BLANK_O=1, SCAN_IDX=0.
  - Reset asserted mid-slot aborts the slot immediately. Stored digit data is lost.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - On the wrap edge, idx advances by 1. idx wraps from NDIG-1 to 0.
  - Every slot is exactly DIV cycles, and the refresh period is NDIG*DIV regardless of DIG_EN.
- Register file:
  - WE=1 with a legal WADDR updates digit[WADDR] and dp[WADDR] on that edge.
  - Writes never stall and never disturb the scan.
- Slot latch:
  - On the wrap edge, NIBBLE, DP, SCAN_IDX and the suppress decision are loaded for the new idx. They are held constant for the whole slot (tear-free).
  - Write forwarding: a write to the incoming digit on the same wrap edge is forwarded, so the new value is displayed.
  - A write to the currently displayed digit mid-slot becomes visible at that digit's next slot.
- Digit output, registered, reflecting cnt in the same cycle:
  - while cnt < BLANK: DIG=0, BLANK_O=1;
  - while cnt >= BLANK: DIG=onehot(idx) and BLANK_O=0, if the digit is lit; otherwise DIG=0 and BLANK_O=1.
- Lit condition: DIG_EN[idx]=1 AND NOT suppressed.
  - Disabled digits still consume their slot.
  - DIG_EN changes take effect at the next slot boundary.
- Suppression (evaluated at the slot latch):
  - With LZS=1, digit i (i>0) is suppressed when its value is 0 and every enabled digit j>i has value 0 with dp[j]=0. Its own dp[i] must also be 0 for suppression.
  - Digit 0 is never suppressed.
  - Disabled digits are ignored in the "higher digits" check.
- SCAN_IDX equals the latched idx. NIBBLE/DP outputs are valid even for blanked slots.
- Invariant: DIG is always one-hot or zero. DIG never changes within a slot except at cnt=BLANK.

Test Plan:
- Reset/scan timing (NDIG=4, DIV=8, BLANK=2, all enabled, all digits written 0..3): after RSTN release, SCAN_IDX steps 0,1,2,3,0 every 8 cycles. DIG=0 for 2 cycles, then 0001/0010/0100/1000 for 6 cycles each. NIBBLE tracks the digit value.
- Write forwarding: write digit1=A on the same edge slot 0→1 wraps -> NIBBLE=A for slot 1. Write digit1=5 mid-slot 1 -> NIBBLE stays A until slot 1 recurs, then shows 5.
- Leading-zero suppression (values 3:0=0,0,4,0, LZS=1) -> digit3 and digit2 DIG=0 with BLANK_O=1; digits 1 and 0 lit. Set dp[3]=1 -> digits 3 and 2 lit (digit2 not suppressed because a higher digit has dp set).
- DIG_EN=1010 -> slots 0 and 2 stay dark but still last 8 cycles each; the period stays 32 cycles.
- Illegal address: WADDR=6 with NDIG=4 -> no register changes.
- Reset mid-slot: RSTN=0 at cnt=5 of slot 2 -> next cycle DIG=0, BLANK_O=1, SCAN_IDX=0, all digit values 0.
